// File: rtl/l2_arb_pkg.sv
// Shared widths, owner codes and FSM state encoding for the L2 port arbiter.
package l2_arb_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned LINE_W = 128;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StServeI,
    StServeD,
    StDone
  } state_e;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// L1/L2 bus bundle around the arbiter. The slave modport is the arbiter's view;
// master is the view of the L1 caches and L2 that surround it.
interface l2_port_arbiter_if;
  import l2_arb_pkg::*;

  logic              ic_read;
  logic [ADDR_W-1:0] ic_addr;
  logic [LINE_W-1:0] ic_rdata;
  logic              ic_ready;
  logic              dc_read;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic [LINE_W-1:0] dc_rdata;
  logic              dc_ready;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_ready;
  logic [1:0]        owner;

  modport slave (
    input  ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, l2_rdata, l2_ready,
    output ic_rdata, ic_ready, dc_rdata, dc_ready, l2_read, l2_write, l2_addr, l2_wdata,
           owner
  );

  modport master (
    output ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, l2_rdata, l2_ready,
    input  ic_rdata, ic_ready, dc_rdata, dc_ready, l2_read, l2_write, l2_addr, l2_wdata,
           owner
  );

endinterface

// File: rtl/l2_arb_grant_select.sv
// Combinational winner selection between I-cache and D-cache requests.
// ARB_ROUND_ROBIN_EN: on conflict grant the requester that did not own the port last.
module l2_arb_grant_select
  import l2_arb_pkg::*;
(
  input  logic       ic_req,
  input  logic       dc_req,
  input  logic [1:0] last_owner,
  output logic       grant_i,
  output logic       grant_d
);

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history; keep the input visibly consumed.
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner;
`endif

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (ic_req && dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_owner == OWNER_D) begin
        grant_i = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
`else
      grant_d = 1'b1;
`endif
    end else begin
      grant_i = ic_req;
      grant_d = dc_req;
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 port between L1 I-cache and D-cache, one transaction at a time.
// Conflict policy set by ARB_ROUND_ROBIN_EN (see l2_arb_grant_select).
module l2_port_arbiter
  import l2_arb_pkg::*;
(
  input logic               clk,
  input logic               rst,
  l2_port_arbiter_if.slave  bus
);

  state_e            state_q;
  logic [1:0]        owner_q;
  logic [1:0]        last_owner_q;
  logic              l2_read_q;
  logic              l2_write_q;
  logic [ADDR_W-1:0] l2_addr_q;
  logic [LINE_W-1:0] l2_wdata_q;
  logic [LINE_W-1:0] ic_rdata_q;
  logic [LINE_W-1:0] dc_rdata_q;
  logic              ic_ready_q;
  logic              dc_ready_q;

  logic dc_req;
  logic grant_i;
  logic grant_d;

  assign dc_req = bus.dc_read | bus.dc_write;

  l2_arb_grant_select u_grant_select (
    .ic_req     (bus.ic_read),
    .dc_req     (dc_req),
    .last_owner (last_owner_q),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= OWNER_NONE;
      last_owner_q <= OWNER_I;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_addr_q    <= '0;
      l2_wdata_q   <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
      ic_ready_q   <= 1'b0;
      dc_ready_q   <= 1'b0;
    end else begin
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q    <= StServeD;
            owner_q    <= OWNER_D;
            l2_addr_q  <= bus.dc_addr;
            l2_wdata_q <= bus.dc_wdata;
            // Simultaneous read and write resolves to the write.
            l2_write_q <= bus.dc_write;
            l2_read_q  <= bus.dc_read & ~bus.dc_write;
          end else if (grant_i) begin
            state_q    <= StServeI;
            owner_q    <= OWNER_I;
            l2_addr_q  <= bus.ic_addr;
            l2_wdata_q <= '0;
            l2_write_q <= 1'b0;
            l2_read_q  <= 1'b1;
          end
        end
        StServeI, StServeD: begin
          if (bus.l2_ready) begin
            if (l2_read_q) begin
              if (state_q == StServeI) begin
                ic_rdata_q <= bus.l2_rdata;
              end else begin
                dc_rdata_q <= bus.l2_rdata;
              end
            end
            ic_ready_q <= (state_q == StServeI);
            dc_ready_q <= (state_q == StServeD);
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            state_q    <= StDone;
          end
        end
        StDone: begin
          last_owner_q <= owner_q;
          owner_q      <= OWNER_NONE;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.owner    = owner_q;
  assign bus.l2_read  = l2_read_q;
  assign bus.l2_write = l2_write_q;
  assign bus.l2_addr  = l2_addr_q;
  assign bus.l2_wdata = l2_wdata_q;
  assign bus.ic_rdata = ic_rdata_q;
  assign bus.dc_rdata = dc_rdata_q;
  assign bus.ic_ready = ic_ready_q;
  assign bus.dc_ready = dc_ready_q;

endmodule
